// File: rtl/vedic_mult_seq_ctrl.sv
// 8x8 unsigned sequential multiplier built from one shared 4x4 Vedic core.
// The four nibble partial products are formed one per cycle and summed into
// a 16-bit accumulator, which is presented on a valid/ready output port.

// 2x2 Urdhva-Tiryakbhyam block.
module vedic_mult_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] out
);
    logic cross_c;

    // Vertical and crosswise products with the crosswise carry.
    always_comb begin
        cross_c = (a[1] & b[0]) & (a[0] & b[1]);
        out[0]  = a[0] & b[0];
        out[1]  = (a[1] & b[0]) ^ (a[0] & b[1]);
        out[2]  = (a[1] & b[1]) ^ cross_c;
        out[3]  = (a[1] & b[1]) & cross_c;
    end
endmodule

// 4x4 Vedic core assembled from four 2x2 blocks.
module vedic_mult_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] out
);
    logic [3:0] p_ll, p_hl, p_lh, p_hh;

    vedic_mult_2bit u_ll (.a(a[1:0]), .b(b[1:0]), .out(p_ll));
    vedic_mult_2bit u_hl (.a(a[3:2]), .b(b[1:0]), .out(p_hl));
    vedic_mult_2bit u_lh (.a(a[1:0]), .b(b[3:2]), .out(p_lh));
    vedic_mult_2bit u_hh (.a(a[3:2]), .b(b[3:2]), .out(p_hh));

    // Sum the shifted 2x2 products; the total never exceeds 8 bits.
    always_comb begin
        out = {4'd0, p_ll}
            + {2'd0, p_hl, 2'd0}
            + {2'd0, p_lh, 2'd0}
            + {p_hh, 4'd0};
    end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | accumulating partial product for step 0..3
// DONE  | result held with out_valid high until out_ready
module vedic_mult_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  ra, rb;
    logic [15:0] acc;
    logic [3:0]  core_a, core_b;
    logic [7:0]  core_out;
    logic [15:0] pp_shifted;

    vedic_mult_4bit u_core (.a(core_a), .b(core_b), .out(core_out));

    // Select the operand nibbles and result alignment for the current step.
    always_comb begin
        core_a     = ra[3:0];
        core_b     = rb[3:0];
        pp_shifted = {8'd0, core_out};
        case (step)
            2'd0: begin
                core_a     = ra[3:0];
                core_b     = rb[3:0];
                pp_shifted = {8'd0, core_out};
            end
            2'd1: begin
                core_a     = ra[3:0];
                core_b     = rb[7:4];
                pp_shifted = {4'd0, core_out, 4'd0};
            end
            2'd2: begin
                core_a     = ra[7:4];
                core_b     = rb[3:0];
                pp_shifted = {4'd0, core_out, 4'd0};
            end
            default: begin
                core_a     = ra[7:4];
                core_b     = rb[7:4];
                pp_shifted = {core_out, 8'd0};
            end
        endcase
    end

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign in_ready = (state == IDLE) && !rst;
    assign result   = acc;

    // Sequencer: accept, four accumulate steps, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            ra        <= 8'd0;
            rb        <= 8'd0;
            acc       <= 16'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        acc   <= 16'd0;
                        step  <= 2'd0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
